// File: rtl/multi_oversample.sv
// Multi-channel oversampling decimator for an interleaved ADC.
// Each channel sums 2^L conversions and emits one widened result per window,
// with a per-channel frame RAM write pointer. Peak-hold tracking is built
// only when MULTI_OVERSAMPLE_PEAK_HOLD_EN is defined; otherwise mon_peak is 0.
module multi_oversample #(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned IN_WIDTH       = 12,
    parameter int unsigned MAX_LOG2_RATIO = 8,
    parameter int unsigned DEPTH_LOG2     = 12,
    localparam int unsigned CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned OUT_WIDTH     = IN_WIDTH + MAX_LOG2_RATIO / 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [IN_WIDTH-1:0]      sample,
    input  logic [CW-1:0]            channel,
    input  logic                     eoc,
    input  logic [3:0]               log2_ratio,
    input  logic                     peak_clear,
    input  logic [CW-1:0]            mon_sel,
    output logic [OUT_WIDTH-1:0]     out_sample,
    output logic [CW-1:0]            out_channel,
    output logic                     out_valid,
    output logic                     wr_en,
    output logic [CW+DEPTH_LOG2-1:0] wr_addr,
    output logic [DEPTH_LOG2-1:0]    mon_head,
    output logic [OUT_WIDTH-1:0]     mon_peak
);

    localparam int unsigned AW   = IN_WIDTH + MAX_LOG2_RATIO;
    localparam int unsigned CNTW = MAX_LOG2_RATIO + 1;

    logic [3:0]            l_q;
    logic [AW-1:0]         acc_q  [CHANNELS];
    logic [CNTW-1:0]       cnt_q  [CHANNELS];
    logic [DEPTH_LOG2-1:0] head_q [CHANNELS];

    logic [3:0]      l_clamped;
    logic            ratio_change;
    logic            chan_ok;
    logic            accept;
    logic [CW-1:0]   chan_idx;
    logic            mon_ok;
    logic [CW-1:0]   mon_idx;
    logic [AW-1:0]   acc_sel;
    logic [CNTW-1:0] cnt_sel;
    logic [CNTW-1:0] cnt_last;
    logic            window_done;
    logic [AW-1:0]   sum;
    logic [AW-1:0]   shifted;
    logic [OUT_WIDTH-1:0] result;

    assign wr_en = out_valid;

    // Decode the incoming conversion and form the window-closing result.
    always_comb begin
        l_clamped    = (log2_ratio > 4'(MAX_LOG2_RATIO)) ? 4'(MAX_LOG2_RATIO) : log2_ratio;
        ratio_change = (l_clamped != l_q);
        chan_ok      = ({1'b0, channel} < (CW+1)'(CHANNELS));
        accept       = eoc && chan_ok;
        chan_idx     = chan_ok ? channel : '0;
        mon_ok       = ({1'b0, mon_sel} < (CW+1)'(CHANNELS));
        mon_idx      = mon_ok ? mon_sel : '0;
        acc_sel      = acc_q[chan_idx];
        cnt_sel      = cnt_q[chan_idx];
        cnt_last     = (CNTW'(1) << l_q) - CNTW'(1);
        window_done  = (cnt_sel == cnt_last);
        sum          = acc_sel + AW'(sample);
        // Left-align so every ratio lands on the same output scale.
        shifted      = sum << (4'(MAX_LOG2_RATIO) - l_q);
        result       = shifted[AW-1:MAX_LOG2_RATIO/2];
    end

    // Accumulate per channel, emit on window close, advance the write pointer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            l_q         <= l_clamped;
            out_valid   <= 1'b0;
            out_sample  <= '0;
            out_channel <= '0;
            wr_addr     <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                acc_q[i]  <= '0;
                cnt_q[i]  <= '0;
                head_q[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (ratio_change) begin
                // Partial windows were built at the old ratio; drop them all.
                l_q <= l_clamped;
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    acc_q[i] <= '0;
                    cnt_q[i] <= '0;
                end
            end else if (accept) begin
                if (window_done) begin
                    acc_q[chan_idx]  <= '0;
                    cnt_q[chan_idx]  <= '0;
                    out_valid        <= 1'b1;
                    out_sample       <= result;
                    out_channel      <= chan_idx;
                    wr_addr          <= {chan_idx, head_q[chan_idx]};
                    head_q[chan_idx] <= head_q[chan_idx] + DEPTH_LOG2'(1);
                end else begin
                    acc_q[chan_idx] <= sum;
                    cnt_q[chan_idx] <= cnt_sel + CNTW'(1);
                end
            end
        end
    end

    // Register the monitored channel's write pointer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mon_head <= '0;
        end else begin
            mon_head <= mon_ok ? head_q[mon_idx] : '0;
        end
    end

`ifdef MULTI_OVERSAMPLE_PEAK_HOLD_EN
    logic [OUT_WIDTH-1:0] peak_q [CHANNELS];

    // Track the largest output per channel; peak_clear restarts tracking, with
    // a coincident output becoming the written channel's new peak.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mon_peak <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                peak_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (out_valid && (out_channel == CW'(i))) begin
                    if (peak_clear || (out_sample > peak_q[i])) begin
                        peak_q[i] <= out_sample;
                    end
                end else if (peak_clear) begin
                    peak_q[i] <= '0;
                end
            end
            mon_peak <= mon_ok ? peak_q[mon_idx] : '0;
        end
    end
`else
    logic unused_peak_clear;

    assign unused_peak_clear = peak_clear;
    assign mon_peak          = '0;
`endif

endmodule

// File: tb/tb_multi_oversample.sv
// Bench for multi_oversample: directed vector table, hand-written corner
// sequences and randomized traffic, all checked every cycle against a
// window-sum reference model.
module tb_multi_oversample;

    localparam int CH = 2;
    localparam int DEPTH = 4096;
`ifdef MULTI_OVERSAMPLE_PEAK_HOLD_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [11:0] sample;
    logic [0:0]  channel;
    logic        eoc;
    logic [3:0]  log2_ratio;
    logic        peak_clear;
    logic [0:0]  mon_sel;
    logic [15:0] out_sample;
    logic [0:0]  out_channel;
    logic        out_valid;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [11:0] mon_head;
    logic [15:0] mon_peak;

    multi_oversample dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample      (sample),
        .channel     (channel),
        .eoc         (eoc),
        .log2_ratio  (log2_ratio),
        .peak_clear  (peak_clear),
        .mon_sel     (mon_sel),
        .out_sample  (out_sample),
        .out_channel (out_channel),
        .out_valid   (out_valid),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .mon_head    (mon_head),
        .mon_peak    (mon_peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: window sum and sample count per channel.
    int    m_l;
    longint m_sum [CH];
    int    m_cnt  [CH];
    int    m_head [CH];
    int    m_peak [CH];
    int    exp_valid, exp_sample, exp_ch, exp_addr, exp_mon_head, exp_mon_peak;

    // Observed output history for sequence-level checks.
    int seen_cnt = 0;
    int last_seen_sample = 0;
    int last_seen_addr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int clampr(input int r);
        return (r > 8) ? 8 : r;
    endfunction

    // One clock: drive inputs, advance the model, then compare all outputs.
    task automatic cycle(input bit e, input int ch, input int smp, input int r,
                         input bit pc, input int ms, input bit rst);
        eoc        = e;
        channel    = 1'(ch);
        sample     = 12'(smp);
        log2_ratio = 4'(r);
        peak_clear = pc;
        mon_sel    = 1'(ms);
        reset_n    = !rst;

        exp_mon_head = m_head[ms];
        exp_mon_peak = PEAK_EN ? m_peak[ms] : 0;
        if (rst) begin
            m_l = clampr(r);
            for (int i = 0; i < CH; i++) begin
                m_sum[i] = 0; m_cnt[i] = 0; m_head[i] = 0; m_peak[i] = 0;
            end
            exp_valid = 0; exp_sample = 0; exp_ch = 0; exp_addr = 0;
            exp_mon_head = 0; exp_mon_peak = 0;
        end else begin
            // Peak tracking acts on the output currently being presented.
            for (int i = 0; i < CH; i++) begin
                if (exp_valid != 0 && exp_ch == i) begin
                    if (pc || exp_sample > m_peak[i]) m_peak[i] = exp_sample;
                end else if (pc) begin
                    m_peak[i] = 0;
                end
            end
            exp_valid = 0;
            if (clampr(r) != m_l) begin
                m_l = clampr(r);
                for (int i = 0; i < CH; i++) begin
                    m_sum[i] = 0; m_cnt[i] = 0;
                end
            end else if (e && ch < CH) begin
                m_sum[ch] += longint'(smp);
                m_cnt[ch]++;
                if (m_cnt[ch] == (1 << m_l)) begin
                    exp_valid  = 1;
                    exp_sample = int'((m_sum[ch] * (64'd1 << (8 - m_l))) / 16);
                    exp_ch     = ch;
                    exp_addr   = ch * DEPTH + m_head[ch];
                    m_head[ch] = (m_head[ch] + 1) % DEPTH;
                    m_sum[ch]  = 0;
                    m_cnt[ch]  = 0;
                end
            end
        end

        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("wr_en", 32'(wr_en), 32'(exp_valid));
        chk("out_sample", 32'(out_sample), 32'(exp_sample));
        chk("out_channel", 32'(out_channel), 32'(exp_ch));
        chk("wr_addr", 32'(wr_addr), 32'(exp_addr));
        chk("mon_head", 32'(mon_head), 32'(exp_mon_head));
        chk("mon_peak", 32'(mon_peak), 32'(exp_mon_peak));
        if (out_valid === 1'b1) begin
            seen_cnt++;
            last_seen_sample = int'(out_sample);
            last_seen_addr   = int'(wr_addr);
        end
    endtask

    task automatic idle(input int r);
        cycle(1'b0, 0, 0, r, 1'b0, 0, 1'b0);
    endtask

    task automatic eocs(input int n, input int ch, input int smp, input int r);
        for (int i = 0; i < n; i++) cycle(1'b1, ch, smp, r, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset(input int r);
        cycle(1'b0, 0, 0, r, 1'b0, 0, 1'b1);
        cycle(1'b0, 0, 0, r, 1'b0, 0, 1'b1);
    endtask

    typedef struct {
        int ratio;
        int ch;
        int smp;
        int n;
        int exp_out;
        int exp_addr;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int base;
        int r;
        tbl[0] = '{4,  0, 'hFFF, 16,  'hFFF0, 'h0000};
        tbl[1] = '{8,  1, 'h800, 256, 'h8000, 'h1000};
        tbl[2] = '{0,  0, 'h123, 1,   'h1230, 'h0001};
        tbl[3] = '{0,  1, 'h456, 1,   'h4560, 'h1001};
        tbl[4] = '{0,  0, 'h123, 1,   'h1230, 'h0002};
        tbl[5] = '{0,  1, 'h456, 1,   'h4560, 'h1002};
        tbl[6] = '{15, 0, 'h001, 256, 'h0010, 'h0003};
        tbl[7] = '{2,  1, 'h100, 4,   'h1000, 'h1003};
        tbl[8] = '{1,  0, 'h003, 2,   'h0030, 'h0004};

        exp_valid = 0; exp_sample = 0; exp_ch = 0; exp_addr = 0;
        m_l = 0;
        for (int i = 0; i < CH; i++) begin
            m_sum[i] = 0; m_cnt[i] = 0; m_head[i] = 0; m_peak[i] = 0;
        end

        do_reset(4);
        chk("reset_out_sample", 32'(out_sample), 32'h0);
        chk("reset_wr_addr", 32'(wr_addr), 32'h0);

        // Directed vectors: one full window each, one output expected.
        for (int v = 0; v < 9; v++) begin
            idle(tbl[v].ratio);
            base = seen_cnt;
            eocs(tbl[v].n, tbl[v].ch, tbl[v].smp, tbl[v].ratio);
            chk($sformatf("tbl%0d_count", v), 32'(seen_cnt - base), 32'd1);
            chk($sformatf("tbl%0d_sample", v), 32'(last_seen_sample), 32'(tbl[v].exp_out));
            chk($sformatf("tbl%0d_addr", v), 32'(last_seen_addr), 32'(tbl[v].exp_addr));
            if (v == 0) begin
                idle(4);
                chk("head_ch0_after_first", 32'(mon_head), 32'd1);
            end
        end

        // Ratio change mid-window discards the partial window.
        idle(4);
        base = seen_cnt;
        for (int i = 0; i < 10; i++) cycle(1'b1, 0, int'($urandom_range(0, 4095)), 4, 1'b0, 0, 1'b0);
        idle(2);
        eocs(4, 0, 'h100, 2);
        chk("ratio_change_count", 32'(seen_cnt - base), 32'd1);
        chk("ratio_change_sample", 32'(last_seen_sample), 32'h1000);

        // An eoc in the ratio-change cycle is not counted.
        base = seen_cnt;
        cycle(1'b1, 1, 'h010, 1, 1'b0, 0, 1'b0);
        eocs(1, 1, 'h010, 1);
        chk("change_eoc_ignored", 32'(seen_cnt - base), 32'd0);
        eocs(1, 1, 'h010, 1);
        chk("change_eoc_count", 32'(seen_cnt - base), 32'd1);
        chk("change_eoc_sample", 32'(last_seen_sample), 32'h0100);

        // Write pointer wrap over 4097 outputs on ch0.
        do_reset(0);
        for (int i = 0; i < 4097; i++) begin
            cycle(1'b1, 0, int'($urandom_range(0, 4095)), 0, 1'b0, 0, 1'b0);
            if (i == 0) chk("wrap_first_addr", 32'(last_seen_addr), 32'h0000);
            if (i == 4095) chk("wrap_last_addr", 32'(last_seen_addr), 32'h0FFF);
        end
        chk("wrap_again_addr", 32'(last_seen_addr), 32'h0000);

        // Reset mid-window drops the partial window.
        idle(4);
        eocs(5, 1, 'h111, 4);
        cycle(1'b1, 1, 'h111, 4, 1'b0, 1, 1'b1);
        chk("midrst_out_sample", 32'(out_sample), 32'h0);
        chk("midrst_wr_addr", 32'(wr_addr), 32'h0);
        chk("midrst_mon_head", 32'(mon_head), 32'h0);
        base = seen_cnt;
        eocs(15, 1, 'h111, 4);
        chk("midrst_no_output", 32'(seen_cnt - base), 32'd0);
        eocs(1, 1, 'h111, 4);
        chk("midrst_new_window", 32'(seen_cnt - base), 32'd1);
        chk("midrst_sample", 32'(last_seen_sample), 32'h1110);

        // Peak hold then a coincident clear.
        do_reset(0);
        cycle(1'b1, 0, 'h0F0, 0, 1'b0, 0, 1'b0);
        idle(0);
        idle(0);
        chk("peak_hold", 32'(mon_peak), PEAK_EN ? 32'h0F00 : 32'h0);
        cycle(1'b1, 0, 'h010, 0, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 0, 0, 1'b1, 0, 1'b0);
        idle(0);
        chk("peak_after_clear", 32'(mon_peak), PEAK_EN ? 32'h0100 : 32'h0);

        // Randomized traffic against the model.
        r = 3;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) r = int'($urandom_range(0, 15));
            if ($urandom_range(0, 999) == 0) begin
                cycle(1'b0, 0, 0, r, 1'b0, 0, 1'b1);
            end else begin
                cycle(($urandom_range(0, 1) == 1), int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 4095)), r, ($urandom_range(0, 19) == 0),
                      int'($urandom_range(0, 1)), 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
